// File: rtl/state_countdown.sv
// MM:SS BCD countdown stage: loads programmed digits on state entry, steps once per second, pause/resume.
// Optional COUNTDOWN_ALARM_BLINK_EN makes the alarm blink at 1 Hz after finishing instead of holding steady.
module state_countdown #(
    parameter logic [2:0] stateID       = 3'd2,
    parameter int         TICKS_PER_SEC = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  currentState,
    input  logic [15:0] digitsIn,
    input  logic        pause,
    output logic [15:0] digitsOut,
    output logic        running,
    output logic        finished,
    output logic        alarm
);

    localparam int             PW        = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [2:0]    prev_state_r;
    logic [15:0]   digits_r;
    logic [PW-1:0] presc_r;
    logic          paused_r;
    logic          finished_r;

    logic          active_s;
    logic          entry_s;
    logic          count_en_s;
    logic          step_s;
    logic          zero_fin_s;
    logic          finish_set_s;
    logic [15:0]   dec_s;
    logic [15:0]   load_s;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic logic [15:0] clamp_bcd(input logic [15:0] d);
        return {clamp_digit(d[15:12], 4'd9), clamp_digit(d[11:8], 4'd9),
                clamp_digit(d[7:4], 4'd5),   clamp_digit(d[3:0], 4'd9)};
    endfunction

    // Only meaningful for a non-zero input; 00:00 is never stepped.
    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        m1 = d[15:12];
        m0 = d[11:8];
        s1 = d[7:4];
        s0 = d[3:0];
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // Entry detection, prescaler enable and step/finish decisions.
    always_comb begin
        active_s     = (currentState == stateID);
        entry_s      = active_s && (prev_state_r != stateID);
        load_s       = clamp_bcd(digitsIn);
        dec_s        = bcd_dec(digits_r);
        count_en_s   = active_s && !entry_s && !paused_r && !finished_r && (digits_r != 16'h0000);
        zero_fin_s   = active_s && !entry_s && !finished_r && (digits_r == 16'h0000);
        step_s       = count_en_s && (presc_r == PRESC_MAX);
        finish_set_s = zero_fin_s || (step_s && (dec_s == 16'h0000));
    end

    // Countdown state: digits, prescaler, pause toggle, sticky finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state_r <= 3'd0;
            digits_r     <= 16'h0000;
            presc_r      <= PW'(0);
            paused_r     <= 1'b0;
            finished_r   <= 1'b0;
        end else begin
            prev_state_r <= currentState;
            if (entry_s) begin
                digits_r   <= load_s;
                presc_r    <= PW'(0);
                paused_r   <= 1'b0;
                finished_r <= 1'b0;
            end else begin
                if (step_s) begin
                    digits_r <= dec_s;
                end
                if (count_en_s) begin
                    presc_r <= step_s ? PW'(0) : (presc_r + PW'(1));
                end
                if (active_s && !finished_r && pause) begin
                    paused_r <= ~paused_r;
                end
                if (finish_set_s) begin
                    finished_r <= 1'b1;
                end
            end
        end
    end

    assign digitsOut = digits_r;
    assign finished  = finished_r;
    // The entry cycle is excluded: nothing counts until the load edge.
    assign running   = active_s && !entry_s && !paused_r && !finished_r;

`ifdef COUNTDOWN_ALARM_BLINK_EN
    localparam logic [PW-1:0] HALF_SEC = PW'(TICKS_PER_SEC / 2);

    logic [PW-1:0] blink_cnt_r;
    logic [PW-1:0] blink_nxt_s;
    logic          alarm_r;

    // Next phase of the 1 Hz blink counter.
    always_comb begin
        if (blink_cnt_r == PRESC_MAX) begin
            blink_nxt_s = PW'(0);
        end else begin
            blink_nxt_s = blink_cnt_r + PW'(1);
        end
    end

    // Blink starts high on the finishing edge and runs while finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_r <= PW'(0);
            alarm_r     <= 1'b0;
        end else if (entry_s) begin
            blink_cnt_r <= PW'(0);
            alarm_r     <= 1'b0;
        end else if (finish_set_s) begin
            blink_cnt_r <= PW'(0);
            alarm_r     <= 1'b1;
        end else if (finished_r) begin
            blink_cnt_r <= blink_nxt_s;
            alarm_r     <= (blink_nxt_s < HALF_SEC);
        end else begin
            blink_cnt_r <= PW'(0);
            alarm_r     <= 1'b0;
        end
    end

    assign alarm = alarm_r;
`else
    assign alarm = finished_r;
`endif

endmodule

// File: tb/tb_state_countdown.sv
// Directed bench for state_countdown with a 4-cycle second; expectations are hand-computed.
module tb_state_countdown;

    logic        clk;
    logic        rst;
    logic [2:0]  currentState;
    logic [15:0] digitsIn;
    logic        pause;
    logic [15:0] digitsOut;
    logic        running;
    logic        finished;
    logic        alarm;

    int checks   = 0;
    int failures = 0;

    state_countdown #(.stateID(3'd2), .TICKS_PER_SEC(4)) dut (
        .clk(clk), .rst(rst), .currentState(currentState), .digitsIn(digitsIn),
        .pause(pause), .digitsOut(digitsOut), .running(running),
        .finished(finished), .alarm(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; currentState = 3'd0; digitsIn = 16'h0000; pause = 1'b0;
        tick(2);
        chk16("rst_digits", digitsOut, 16'h0000);
        chk1("rst_running", running, 1'b0);
        chk1("rst_finished", finished, 1'b0);
        chk1("rst_alarm", alarm, 1'b0);
        rst = 1'b0;
        tick(1);

        // Basic countdown with borrow across seconds
        digitsIn = 16'h0102; currentState = 3'd2;
        tick(1);
        chk16("load_0102", digitsOut, 16'h0102);
        chk1("load_running", running, 1'b1);
        tick(3);
        chk16("pre_step", digitsOut, 16'h0102);
        tick(1);
        chk16("step_0101", digitsOut, 16'h0101);
        tick(4);
        chk16("step_0100", digitsOut, 16'h0100);
        tick(4);
        chk16("borrow_0059", digitsOut, 16'h0059);
        tick(4);
        chk16("step_0058", digitsOut, 16'h0058);
        currentState = 3'd0;
        tick(1);
        chk1("inactive_running", running, 1'b0);

        // Count to 00:00 and hold
        digitsIn = 16'h0001; currentState = 3'd2;
        tick(1);
        chk16("load_0001", digitsOut, 16'h0001);
        chk1("load_not_finished", finished, 1'b0);
        tick(3);
        chk1("fin_before", finished, 1'b0);
        tick(1);
        chk16("fin_digits", digitsOut, 16'h0000);
        chk1("fin_flag", finished, 1'b1);
        chk1("fin_running", running, 1'b0);
        chk1("fin_alarm0", alarm, 1'b1);
`ifdef COUNTDOWN_ALARM_BLINK_EN
        tick(1); chk1("blink_1", alarm, 1'b1);
        tick(1); chk1("blink_2", alarm, 1'b0);
        tick(1); chk1("blink_3", alarm, 1'b0);
        tick(1); chk1("blink_4", alarm, 1'b1);
        tick(1); chk1("blink_5", alarm, 1'b1);
        tick(1); chk1("blink_6", alarm, 1'b0);
        tick(14);
`else
        tick(20);
        chk1("steady_alarm", alarm, 1'b1);
`endif
        chk16("hold_0000", digitsOut, 16'h0000);
        chk1("hold_finished", finished, 1'b1);
        currentState = 3'd0;
        tick(1);

        // Zero load finishes on the following edge
        digitsIn = 16'h0000; currentState = 3'd2;
        tick(1);
        chk16("zero_load", digitsOut, 16'h0000);
        chk1("zero_fin_clear", finished, 1'b0);
        chk1("zero_alarm_clear", alarm, 1'b0);
        tick(1);
        chk1("zero_fin_set", finished, 1'b1);
        tick(8);
        chk16("zero_hold", digitsOut, 16'h0000);
        currentState = 3'd0;
        tick(1);

        // Clamping of out-of-range digits
        digitsIn = 16'hFA7C; currentState = 3'd2;
        tick(1);
        chk16("clamp_9959", digitsOut, 16'h9959);
        tick(4);
        chk16("clamp_step", digitsOut, 16'h9958);
        currentState = 3'd0;
        tick(1);

        // Pause two cycles into a second, resume continues the partial second
        digitsIn = 16'h0010; currentState = 3'd2;
        tick(1);
        chk16("p_load", digitsOut, 16'h0010);
        tick(1);
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        chk1("p_running", running, 1'b0);
        tick(10);
        chk16("p_hold", digitsOut, 16'h0010);
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        chk1("resume_running", running, 1'b1);
        tick(1);
        chk16("resume_1", digitsOut, 16'h0010);
        tick(1);
        chk16("resume_step", digitsOut, 16'h0009);
        currentState = 3'd0;
        tick(1);

        // Leave mid-count, digits hold, re-entry reloads
        digitsIn = 16'h0007; currentState = 3'd2;
        tick(1);
        tick(8);
        chk16("leave_at", digitsOut, 16'h0005);
        tick(2);
        currentState = 3'd0;
        tick(10);
        chk16("leave_hold", digitsOut, 16'h0005);
        chk1("leave_running", running, 1'b0);
        digitsIn = 16'h0003; currentState = 3'd2;
        tick(1);
        chk16("reenter_load", digitsOut, 16'h0003);
        tick(2);

        // Asynchronous reset mid-count, then reload on release
        rst = 1'b1;
        #1;
        chk16("arst_digits", digitsOut, 16'h0000);
        chk1("arst_running", running, 1'b0);
        chk1("arst_finished", finished, 1'b0);
        chk1("arst_alarm", alarm, 1'b0);
        tick(1);
        digitsIn = 16'h0042;
        rst = 1'b0;
        tick(1);
        chk16("post_rst_load", digitsOut, 16'h0042);
        tick(4);
        chk16("post_rst_step", digitsOut, 16'h0041);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
